// File: rtl/load_align_unit_if.sv
// Load request / DM / response bundle for load_align_unit.
interface load_align_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic        dm_rd_en;
  logic [31:0] dm_addr;
  logic [31:0] dm_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_exc;
  logic [4:0]  resp_exc_code;

  modport slave (
    input  req_valid, req_addr, req_type, dm_rdata, resp_ready,
    output req_ready, dm_rd_en, dm_addr, resp_valid, resp_data, resp_exc, resp_exc_code
  );

  modport master (
    output req_valid, req_addr, req_type, dm_rdata, resp_ready,
    input  req_ready, dm_rd_en, dm_addr, resp_valid, resp_data, resp_exc, resp_exc_code
  );
endinterface

// File: rtl/load_align_unit.sv
// Load alignment unit: one in-flight stage feeding a 3-entry in-order result FIFO.
// Misalignment exceptions are enabled by defining LOAD_ADDR_EXC_EN.
module load_align_unit (
  input  logic              clk,
  input  logic              reset,
  load_align_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_t;

  load_t       w_type;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_pending;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_push_data;

  logic        r_if_valid;
  logic [1:0]  r_if_off;
  load_t       r_if_type;
  logic        r_if_exc;

  logic [31:0] r_fifo_data [0:2];
  logic        r_fifo_exc  [0:2];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_count;

  function automatic logic [1:0] f_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    case (bus.req_type)
      3'b001:  w_type = LT_LH;
      3'b010:  w_type = LT_LHU;
      3'b011:  w_type = LT_LB;
      3'b100:  w_type = LT_LBU;
      default: w_type = LT_LW;
    endcase
  end

`ifdef LOAD_ADDR_EXC_EN
  assign w_misaligned = ((w_type == LT_LW) && (bus.req_addr[1:0] != 2'b00)) ||
                        (((w_type == LT_LH) || (w_type == LT_LHU)) && bus.req_addr[0]);
`else
  assign w_misaligned = 1'b0;
`endif

  // Ready depends on registered occupancy only, never on resp_ready.
  assign w_pending     = {1'b0, r_count} + {2'b00, r_if_valid};
  assign bus.req_ready = (w_pending < 3'd3);
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign bus.dm_rd_en  = w_accept && !w_misaligned;
  assign bus.dm_addr   = {bus.req_addr[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_valid <= 1'b0;
      r_if_off   <= 2'b00;
      r_if_type  <= LT_LW;
      r_if_exc   <= 1'b0;
    end else begin
      r_if_valid <= w_accept;
      if (w_accept) begin
        r_if_off  <= bus.req_addr[1:0];
        r_if_type <= w_type;
        r_if_exc  <= w_misaligned;
      end
    end
  end

  assign w_half = r_if_off[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];

  always_comb begin
    case (r_if_off)
      2'b00:   w_byte = bus.dm_rdata[7:0];
      2'b01:   w_byte = bus.dm_rdata[15:8];
      2'b10:   w_byte = bus.dm_rdata[23:16];
      default: w_byte = bus.dm_rdata[31:24];
    endcase
  end

  always_comb begin
    w_push_data = bus.dm_rdata;
    case (r_if_type)
      LT_LH:   w_push_data = {{16{w_half[15]}}, w_half};
      LT_LHU:  w_push_data = {16'h0000, w_half};
      LT_LB:   w_push_data = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  w_push_data = {24'h000000, w_byte};
      default: w_push_data = bus.dm_rdata;
    endcase
    if (r_if_exc) w_push_data = '0;
  end

  assign w_push = r_if_valid;
  assign w_pop  = bus.resp_valid && bus.resp_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_exc[r_wr_ptr]  <= r_if_exc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.resp_valid    = (r_count != 2'd0);
  assign bus.resp_data     = bus.resp_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.resp_exc      = bus.resp_valid && r_fifo_exc[r_rd_ptr];
  assign bus.resp_exc_code = bus.resp_exc ? 5'd4 : 5'd0;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed-vector bench for load_align_unit with a one-cycle-latency DM model.
module tb_load_align_unit;

  logic clk;
  logic reset;
  load_align_unit_if bus ();

  load_align_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h876543A1;
    if (a == 32'h0000_1000) return 32'h12F4807F;
    return {16'hBEEF, a[15:0]};
  endfunction

  // DM returns the addressed word one cycle after the strobe, garbage otherwise.
  always @(posedge clk)
    bus.dm_rdata <= bus.dm_rd_en ? memw(bus.dm_addr) : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_exc;
  } vec_t;

  vec_t vt [17];
  logic [31:0] exp_q [$];
  int acc;

  initial begin
    vt[0]  = '{3'b011, 32'h0000_0003, 32'hFFFFFF87, 1'b0};
    vt[1]  = '{3'b100, 32'h0000_0001, 32'h00000043, 1'b0};
    vt[2]  = '{3'b001, 32'h0000_0002, 32'hFFFF8765, 1'b0};
    vt[3]  = '{3'b010, 32'h0000_0000, 32'h000043A1, 1'b0};
    vt[4]  = '{3'b000, 32'h0000_0000, 32'h876543A1, 1'b0};
    vt[5]  = '{3'b011, 32'h0000_0000, 32'hFFFFFFA1, 1'b0};
    vt[6]  = '{3'b100, 32'h0000_0002, 32'h00000065, 1'b0};
    vt[7]  = '{3'b001, 32'h0000_0000, 32'h000043A1, 1'b0};
    vt[8]  = '{3'b010, 32'h0000_1002, 32'h000012F4, 1'b0};
    vt[9]  = '{3'b001, 32'h0000_1000, 32'hFFFF807F, 1'b0};
    vt[10] = '{3'b011, 32'h0000_1001, 32'hFFFFFF80, 1'b0};
    vt[11] = '{3'b100, 32'h0000_1003, 32'h00000012, 1'b0};
    vt[12] = '{3'b111, 32'h0000_1000, 32'h12F4807F, 1'b0};
    vt[13] = '{3'b101, 32'h0000_0000, 32'h876543A1, 1'b0};
`ifdef LOAD_ADDR_EXC_EN
    vt[14] = '{3'b000, 32'h0000_1002, 32'h00000000, 1'b1};
    vt[15] = '{3'b001, 32'h0000_1001, 32'h00000000, 1'b1};
    vt[16] = '{3'b010, 32'h0000_1003, 32'h00000000, 1'b1};
`else
    vt[14] = '{3'b000, 32'h0000_1002, 32'h12F4807F, 1'b0};
    vt[15] = '{3'b001, 32'h0000_1001, 32'hFFFF807F, 1'b0};
    vt[16] = '{3'b010, 32'h0000_1003, 32'h000012F4, 1'b0};
`endif

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_type   = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req_ready",  32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data",  bus.resp_data, 32'h0);
    chk("rst_resp_exc",   32'(bus.resp_exc), 32'd0);
    chk("rst_exc_code",   32'(bus.resp_exc_code), 32'd0);
    chk("rst_dm_rd_en",   32'(bus.dm_rd_en), 32'd0);

    // Single transactions: alignment, extension, exceptions, exact latency
    for (int i = 0; i < 17; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = vt[i].addr;
      bus.req_type  = vt[i].typ;
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'd1);
      chk($sformatf("v%0d_dm_rd_en", i), 32'(bus.dm_rd_en), 32'(!vt[i].exp_exc));
      chk($sformatf("v%0d_dm_addr", i), bus.dm_addr, {vt[i].addr[31:2], 2'b00});
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_early_valid", i), 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_resp_valid", i), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("v%0d_resp_data", i), bus.resp_data, vt[i].exp_data);
      chk($sformatf("v%0d_resp_exc", i), 32'(bus.resp_exc), 32'(vt[i].exp_exc));
      chk($sformatf("v%0d_exc_code", i), 32'(bus.resp_exc_code),
          vt[i].exp_exc ? 32'd4 : 32'd0);
      @(negedge clk);
    end

    // 8 back-to-back LW, result k visible two negedges after its request
    bus.resp_ready = 1'b1;
    bus.req_type   = 3'b000;
    for (int k = 0; k < 11; k++) begin
      bus.req_valid = (k < 8);
      bus.req_addr  = 32'h2000 + 32'(4 * k);
      #1;
      if (k < 8) chk($sformatf("b2b%0d_req_ready", k), 32'(bus.req_ready), 32'd1);
      if (k >= 2 && k < 10) begin
        chk($sformatf("b2b%0d_valid", k), 32'(bus.resp_valid), 32'd1);
        chk($sformatf("b2b%0d_data", k), bus.resp_data, {16'hBEEF, 16'h2000 + 16'(4 * (k - 2))});
      end else begin
        chk($sformatf("b2b%0d_idle", k), 32'(bus.resp_valid), 32'd0);
      end
      @(negedge clk);
    end

    // Back-pressure: exactly 3 accepted, head held stable, then drain in order
    bus.resp_ready = 1'b0;
    acc = 0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h3000 + 32'(4 * acc);
      #1;
      chk($sformatf("bp%0d_req_ready", k), 32'(bus.req_ready), (k < 3) ? 32'd1 : 32'd0);
      if (k >= 2) chk($sformatf("bp%0d_head", k), bus.resp_data, 32'hBEEF3000);
      if (bus.req_ready) begin
        exp_q.push_back({16'hBEEF, 16'h3000 + 16'(4 * acc)});
        acc++;
      end
      @(negedge clk);
    end
    chk("bp_accepted", 32'(acc), 32'd3);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("drain%0d_valid", k), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("drain%0d_data", k), bus.resp_data,
          (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
      @(negedge clk);
    end
    #1;
    chk("drain_empty", 32'(bus.resp_valid), 32'd0);
    chk("drain_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);

    // Reset with two buffered loads and one in flight
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h4000 + 32'(4 * k);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(bus.resp_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_data", bus.resp_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("post_rst%0d_valid", k), 32'(bus.resp_valid), 32'd0);
      chk($sformatf("post_rst%0d_ready", k), 32'(bus.req_ready), 32'd1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
